coh_chan_arb_buf: RTL and testbench
===================================

Name: coh_chan_arb_buf

Overview:
- Parametrised ingress buffer and arbiter for coherence message channels.
- Takes N_CH independent valid/ready channels, each carrying {coh_msg, addr, line, req_id}, and buffers each channel in its own DEPTH-entry FIFO.
- Merges the channels onto one output channel using round-robin or fixed-priority arbitration.
- Sits in front of the LLC/L2 input stage, replacing single-slot per-channel input registers.

Parameters:
- N_CH, 3, number of input channels (1..8).
- DEPTH, 4, entries per channel FIFO (power of two, 2..16).
- COH_MSG_W, 5, coherence message type width.
- ADDR_W, 28, line address width.
- LINE_W, 128, line data width.
- ID_W, 4, cache id width.
- PRIO_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  N_CH  per-channel request valid.
- in_ready  out  N_CH  per-channel accept.
- in_coh_msg  in  N_CH*COH_MSG_W  flattened; channel i at [i*COH_MSG_W +: COH_MSG_W].
- in_addr  in  N_CH*ADDR_W  flattened, same packing.
- in_line  in  N_CH*LINE_W  flattened, same packing.
- in_req_id  in  N_CH*ID_W  flattened, same packing.
- out_valid  out  1  merged output valid.
- out_ready  in  1  downstream accept.
- out_coh_msg  out  COH_MSG_W  selected head message.
- out_addr  out  ADDR_W  selected head address.
- out_line  out  LINE_W  selected head line.
- out_req_id  out  ID_W  selected head requester id.
- out_chan  out  max(1,$clog2(N_CH))  index of the granted channel.
- occupancy  out  N_CH*($clog2(DEPTH)+1)  per-channel entry count, flattened.

Behaviour:
- Reset, synchronous, rst=1 at an edge:
  - All FIFOs empty, counts 0.
  - in_ready all 1 from the first cycle after reset.
  - out_valid=0, out_chan=0, round-robin pointer=0, grant lock cleared.
  - Data outputs are don't-care while out_valid=0.
- Reset mid-operation discards all buffered entries, and any handshake in that cycle is ignored.
- Push:
  - in_ready[i] = (count[i] != DEPTH), computed from registered state only; there is no full-and-pop bypass.
  - Push happens on in_valid[i] && in_ready[i].
  - Write pointer wraps modulo DEPTH.
- Pop:
  - Happens on out_valid && out_ready, from channel out_chan.
  - Read pointer wraps modulo DEPTH.
- Latency:
  - No input-to-output bypass. An entry pushed at edge t can first appear on out_* during cycle t+1.
  - Minimum latency is 1 cycle; sustained throughput is 1 message per cycle.
- Simultaneous push and pop on the same channel: count unchanged. This is legal at any count < DEPTH, including count=1.
- Arbitration, combinational over the non-empty set E:
  - out_valid = (E != 0) or lock.
  - PRIO_MODE=0: grant the first non-empty channel at or after rr_ptr, cyclically. After each pop, rr_ptr <= (granted+1) mod N_CH.
  - PRIO_MODE=1: grant the lowest non-empty index; rr_ptr is unused.
- Grant lock:
  - If out_valid && !out_ready at an edge, lock is set and the grant is frozen on the same channel.
  - out_chan and all out_* hold stable until the pop.
  - Lock clears on pop.
  - A higher-priority arrival must not change the grant while locked.
- out_* are driven from the head entry of the granted FIFO.
- occupancy[i] = count[i], registered; range 0..DEPTH.
- N_CH=1: out_chan is tied to 0 and the arbiter degenerates to a pass-through FIFO.
- Each FIFO is ordered in-order and loss-free; no reordering within a channel.

Test Plan:
- Reset then idle: after rst=1 for 2 cycles → in_ready=3'b111, out_valid=0, occupancy all 0.
- Single message, out_ready=1:
  - Stimulus: push ch1 {coh_msg=5'h2, addr=28'h0ABCDEF, req_id=4'h3} at edge t.
  - Required: out_valid=1, out_chan=1, fields match during cycle t+1; popped at edge t+1; out_valid=0 at t+2.
- Fill and backpressure, out_ready=0:
  - Stimulus: push 4 messages on ch0.
  - Required: occupancy[0]=4, in_ready[0]=0. A 5th in_valid is not accepted.
  - Then raise out_ready: messages emerge in push order, and in_ready[0]=1 the cycle after the first pop.
- Round-robin fairness, PRIO_MODE=0:
  - Stimulus: all 3 FIFOs hold 2 entries each, out_ready=1.
  - Required: out_chan sequence 0,1,2,0,1,2.
- Fixed priority with lock, PRIO_MODE=1:
  - Stimulus: ch2 non-empty, out_ready=0; ch0 receives a push the next cycle.
  - Required: out_chan stays 2 until out_ready=1 pops it, then ch0 is granted.
- Concurrent push/pop and mid-operation reset:
  - Stimulus: ch1 at count=1 with a push and pop in the same cycle → occupancy[1]=1.
  - Then assert rst with 3 entries buffered → next cycle occupancy all 0, out_valid=0.

Source files
------------

// File: rtl/coh_chan_arb_buf.sv
// Per-channel coherence message FIFOs merged onto one output channel.
// Round-robin or fixed-priority arbitration; the grant is locked while the output is stalled.
module coh_chan_arb_buf #(
   parameter int N_CH      = 3,
   parameter int DEPTH     = 4,
   parameter int COH_MSG_W = 5,
   parameter int ADDR_W    = 28,
   parameter int LINE_W    = 128,
   parameter int ID_W      = 4,
   parameter int PRIO_MODE = 0,
   localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
   localparam int CNT_W    = $clog2(DEPTH) + 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_CH-1:0]             in_valid,
   output logic [N_CH-1:0]             in_ready,
   input  logic [N_CH*COH_MSG_W-1:0]   in_coh_msg,
   input  logic [N_CH*ADDR_W-1:0]      in_addr,
   input  logic [N_CH*LINE_W-1:0]      in_line,
   input  logic [N_CH*ID_W-1:0]        in_req_id,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [COH_MSG_W-1:0]        out_coh_msg,
   output logic [ADDR_W-1:0]           out_addr,
   output logic [LINE_W-1:0]           out_line,
   output logic [ID_W-1:0]             out_req_id,
   output logic [CH_W-1:0]             out_chan,
   output logic [N_CH*CNT_W-1:0]       occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = COH_MSG_W + ADDR_W + LINE_W + ID_W;

   logic [ENT_W-1:0] mem_q [N_CH][DEPTH];
   logic [ENT_W-1:0] ent_in [N_CH];
   logic [PTR_W-1:0] wr_ptr_q [N_CH];
   logic [PTR_W-1:0] rd_ptr_q [N_CH];
   logic [CNT_W-1:0] cnt_q [N_CH];
   logic [CNT_W-1:0] cnt_d [N_CH];
   logic [N_CH-1:0]  push;
   logic [N_CH-1:0]  pop_ch;
   logic [N_CH-1:0]  nonempty;
   logic [CH_W-1:0]  grant;
   logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CH_W-1:0]  lock_ch_q, lock_ch_d;
   logic             lock_q, lock_d;
   logic             pop;
   logic             found;
   int               idx;

   // Ready depends on registered count only: a full FIFO never accepts, even when popping.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         nonempty[i] = (cnt_q[i] != '0);
         in_ready[i] = (cnt_q[i] != CNT_W'(DEPTH));
         push[i]     = in_valid[i] && in_ready[i];
         ent_in[i]   = {in_coh_msg[i*COH_MSG_W +: COH_MSG_W], in_addr[i*ADDR_W +: ADDR_W],
                        in_line[i*LINE_W +: LINE_W], in_req_id[i*ID_W +: ID_W]};
         occupancy[i*CNT_W +: CNT_W] = cnt_q[i];
      end
   end

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      if (lock_q) begin
         grant = lock_ch_q;
      end else if (PRIO_MODE != 0) begin
         for (int k = 0; k < N_CH; k++) begin
            if (!found && nonempty[k]) begin
               grant = CH_W'(k);
               found = 1'b1;
            end
         end
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!found && nonempty[idx]) begin
               grant = CH_W'(idx);
               found = 1'b1;
            end
         end
      end
   end

   assign out_valid = (|nonempty) || lock_q;
   assign out_chan  = grant;
   assign pop       = out_valid && out_ready;
   assign {out_coh_msg, out_addr, out_line, out_req_id} = mem_q[grant][rd_ptr_q[grant]];

   always_comb begin
      lock_d    = lock_q;
      lock_ch_d = lock_ch_q;
      rr_ptr_d  = rr_ptr_q;
      if (pop) begin
         lock_d   = 1'b0;
         rr_ptr_d = (grant == CH_W'(N_CH - 1)) ? '0 : grant + CH_W'(1);
      end else if (out_valid) begin
         lock_d    = 1'b1;
         lock_ch_d = grant;
      end
      for (int i = 0; i < N_CH; i++) begin
         pop_ch[i] = pop && (grant == CH_W'(i));
         cnt_d[i]  = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop_ch[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_q    <= 1'b0;
         lock_ch_q <= '0;
         rr_ptr_q  <= '0;
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i]    <= '0;
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
         end
      end else begin
         lock_q    <= lock_d;
         lock_ch_q <= lock_ch_d;
         rr_ptr_q  <= rr_ptr_d;
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
            if (push[i])   wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
            if (pop_ch[i]) rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
         end
      end
   end

   // Storage carries no reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_CH; i++) begin
         if (push[i]) mem_q[i][wr_ptr_q[i]] <= ent_in[i];
      end
   end

endmodule

// File: tb/tb_coh_chan_arb_buf.sv
// Scoreboard bench: round-robin instance checked per channel, fixed-priority instance for grant lock.
module tb_coh_chan_arb_buf;

   typedef logic [164:0] ent_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;

   logic [2:0]   a_in_valid = '0, a_in_ready;
   logic [14:0]  a_msg = '0;
   logic [83:0]  a_addr = '0;
   logic [383:0] a_line = '0;
   logic [11:0]  a_id = '0;
   logic         a_out_valid, a_out_ready = 1'b0;
   logic [4:0]   a_out_msg;
   logic [27:0]  a_out_addr;
   logic [127:0] a_out_line;
   logic [3:0]   a_out_id;
   logic [1:0]   a_out_chan;
   logic [8:0]   a_occ;

   logic [2:0]   b_in_valid = '0, b_in_ready;
   logic [14:0]  b_msg = '0;
   logic [83:0]  b_addr = '0;
   logic [383:0] b_line = '0;
   logic [11:0]  b_id = '0;
   logic         b_out_valid, b_out_ready = 1'b0;
   logic [4:0]   b_out_msg;
   logic [27:0]  b_out_addr;
   logic [127:0] b_out_line;
   logic [3:0]   b_out_id;
   logic [1:0]   b_out_chan;
   logic [8:0]   b_occ;

   ent_t cur_a [3];
   ent_t sbq [3][$];
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   coh_chan_arb_buf #(.PRIO_MODE(0)) dut (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_coh_msg(a_msg), .in_addr(a_addr), .in_line(a_line), .in_req_id(a_id),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_coh_msg(a_out_msg),
      .out_addr(a_out_addr), .out_line(a_out_line), .out_req_id(a_out_id),
      .out_chan(a_out_chan), .occupancy(a_occ));

   coh_chan_arb_buf #(.PRIO_MODE(1)) dut_fp (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_coh_msg(b_msg), .in_addr(b_addr), .in_line(b_line), .in_req_id(b_id),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_coh_msg(b_out_msg),
      .out_addr(b_out_addr), .out_line(b_out_line), .out_req_id(b_out_id),
      .out_chan(b_out_chan), .occupancy(b_occ));

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic ent_t rand_ent();
      return {5'($urandom), 28'($urandom), {$urandom, $urandom, $urandom, $urandom}, 4'($urandom)};
   endfunction

   task automatic drive_a(input int c, input ent_t e);
      cur_a[c] = e;
      a_msg[c*5 +: 5]      = e[164:160];
      a_addr[c*28 +: 28]   = e[159:132];
      a_line[c*128 +: 128] = e[131:4];
      a_id[c*4 +: 4]       = e[3:0];
   endtask

   task automatic drive_b(input int c, input ent_t e);
      b_msg[c*5 +: 5]      = e[164:160];
      b_addr[c*28 +: 28]   = e[159:132];
      b_line[c*128 +: 128] = e[131:4];
      b_id[c*4 +: 4]       = e[3:0];
   endtask

   // Record the handshakes visible this cycle, then advance one clock and settle.
   task automatic cycle();
      int   c;
      ent_t e;
      if (!rst) begin
         for (int i = 0; i < 3; i++)
            if (a_in_valid[i] && a_in_ready[i]) sbq[i].push_back(cur_a[i]);
         if (a_out_valid && a_out_ready) begin
            c = int'(a_out_chan);
            if (c > 2 || sbq[c].size() == 0) begin
               chk("sb_unexpected_pop", 256'(c), 256'(99));
            end else begin
               e = sbq[c].pop_front();
               chk("sb_data", 256'({a_out_msg, a_out_addr, a_out_line, a_out_id}), 256'(e));
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain_a();
      for (int k = 0; k < 16 && a_out_valid; k++) cycle();
      chk("drain_done", 256'(a_out_valid), 256'(0));
   endtask

   initial begin
      int   seq [6];
      ent_t e, eb0, eb2;
      seq = '{0, 1, 2, 0, 1, 2};

      cycle();
      cycle();
      rst = 1'b0;
      chk("rst_in_ready", 256'(a_in_ready), 256'(3'b111));
      chk("rst_out_valid", 256'(a_out_valid), 256'(0));
      chk("rst_occ", 256'(a_occ), 256'(0));
      chk("rst_out_chan", 256'(a_out_chan), 256'(0));
      chk("rst_fp_valid", 256'(b_out_valid), 256'(0));

      // Two entries per channel, then drain with out_ready high.
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 3; c++) drive_a(c, rand_ent());
         a_in_valid = 3'b111;
         cycle();
      end
      a_in_valid = '0;
      chk("rr_occ_full", 256'(a_occ), 256'({3'd2, 3'd2, 3'd2}));
      a_out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         chk("rr_valid", 256'(a_out_valid), 256'(1));
         chk("rr_chan", 256'(a_out_chan), 256'(seq[k]));
         cycle();
      end
      chk("rr_empty", 256'(a_out_valid), 256'(0));

      // Single message on ch1.
      e = {5'h2, 28'h0ABCDEF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 4'h3};
      drive_a(1, e);
      a_in_valid = 3'b010;
      cycle();
      a_in_valid = '0;
      chk("single_valid", 256'(a_out_valid), 256'(1));
      chk("single_chan", 256'(a_out_chan), 256'(1));
      chk("single_msg", 256'(a_out_msg), 256'(5'h2));
      chk("single_addr", 256'(a_out_addr), 256'(28'h0ABCDEF));
      chk("single_id", 256'(a_out_id), 256'(4'h3));
      cycle();
      chk("single_gone", 256'(a_out_valid), 256'(0));

      // Fill ch0 under backpressure.
      a_out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive_a(0, rand_ent());
         a_in_valid = 3'b001;
         cycle();
      end
      chk("fill_occ", 256'(a_occ[2:0]), 256'(4));
      chk("fill_ready", 256'(a_in_ready[0]), 256'(0));
      drive_a(0, rand_ent());
      cycle();
      a_in_valid = '0;
      chk("fill_reject", 256'(a_occ[2:0]), 256'(4));
      chk("fill_chan", 256'(a_out_chan), 256'(0));
      a_out_ready = 1'b1;
      cycle();
      chk("fill_ready_back", 256'(a_in_ready[0]), 256'(1));
      chk("fill_occ_after_pop", 256'(a_occ[2:0]), 256'(3));
      drain_a();

      // Push and pop on ch1 in the same cycle at count 1.
      a_out_ready = 1'b0;
      drive_a(1, rand_ent());
      a_in_valid = 3'b010;
      cycle();
      drive_a(1, rand_ent());
      a_out_ready = 1'b1;
      chk("pp_chan", 256'(a_out_chan), 256'(1));
      cycle();
      a_in_valid = '0;
      a_out_ready = 1'b0;
      chk("pp_occ", 256'(a_occ[5:3]), 256'(1));

      // Three buffered entries, then reset with handshakes pending.
      drive_a(0, rand_ent());
      drive_a(2, rand_ent());
      a_in_valid = 3'b101;
      cycle();
      chk("pre_rst_occ", 256'(a_occ), 256'({3'd1, 3'd1, 3'd1}));
      rst = 1'b1;
      a_in_valid = 3'b111;
      a_out_ready = 1'b1;
      cycle();
      rst = 1'b0;
      a_in_valid = '0;
      for (int i = 0; i < 3; i++) sbq[i].delete();
      chk("mid_rst_occ", 256'(a_occ), 256'(0));
      chk("mid_rst_valid", 256'(a_out_valid), 256'(0));
      chk("mid_rst_ready", 256'(a_in_ready), 256'(3'b111));

      drive_a(2, rand_ent());
      a_in_valid = 3'b100;
      cycle();
      a_in_valid = '0;
      chk("post_rst_chan", 256'(a_out_chan), 256'(2));
      drain_a();

      // Fixed priority: ch2 locked while ch0 arrives.
      eb2 = rand_ent();
      eb0 = rand_ent();
      drive_b(2, eb2);
      b_in_valid = 3'b100;
      cycle();
      drive_b(0, eb0);
      b_in_valid = 3'b001;
      chk("fp_first_chan", 256'(b_out_chan), 256'(2));
      cycle();
      b_in_valid = '0;
      for (int k = 0; k < 2; k++) begin
         chk("fp_lock_chan", 256'(b_out_chan), 256'(2));
         chk("fp_lock_addr", 256'(b_out_addr), 256'(eb2[159:132]));
         cycle();
      end
      b_out_ready = 1'b1;
      chk("fp_pop_chan", 256'(b_out_chan), 256'(2));
      cycle();
      chk("fp_next_chan", 256'(b_out_chan), 256'(0));
      chk("fp_next_addr", 256'(b_out_addr), 256'(eb0[159:132]));
      cycle();
      chk("fp_empty", 256'(b_out_valid), 256'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
